// File: rtl/counter_ext_pkg.sv
// Shared types and defaults for the extended-count sampler.
// Provides default count/epoch widths, the snapshot record layout and the
// wrap-decode classification used by the top level.
package counter_ext_pkg;

  localparam int CW_DEF = 8;
  localparam int EW_DEF = 8;

  // Snapshot as stored in the FIFO: epoch in the upper bits, raw count below.
  typedef struct packed {
    logic [EW_DEF-1:0] epoch;
    logic [CW_DEF-1:0] count;
  } snap_t;

  typedef enum logic [1:0] {
    WRAP_NONE = 2'd0,
    WRAP_UP   = 2'd1,
    WRAP_DOWN = 2'd2,
    WRAP_BAD  = 2'd3
  } wrap_e;

  // An overflow pulse is only meaningful when the count has just landed on
  // zero (counting up) or all-ones (counting down); anything else is malformed.
  function automatic wrap_e wrap_decode(input logic ovf, input logic is_zero,
                                        input logic is_ones);
    wrap_e w;
    w = WRAP_NONE;
    if (ovf) begin
      if (is_zero)      w = WRAP_UP;
      else if (is_ones) w = WRAP_DOWN;
      else              w = WRAP_BAD;
    end
    return w;
  endfunction

endpackage

// File: rtl/snap_fifo.sv
// Generic synchronous FIFO, W bits wide, DEPTH entries (power of two).
// Ports: push_i/wdata_i write, pop_i read, rdata_o head (0 when empty),
// full_o/empty_o/level_o status. Caller must not push when full unless popping.
module snap_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign level_o = level_q;
  // Gate the head so a cleared FIFO presents zero rather than stale data.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push_i, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset: reads are gated by empty_o.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/counter_extend_sampler.sv
// Extends an upstream CW-bit counter with an EW-bit signed epoch and buffers
// on-demand {epoch,count} snapshots in a FIFO drained over valid/ready.
// Ports: count/overflow from the counter, sample_req capture strobe,
// out_* drain port, epoch/fifo_level/drop_cnt/proto_err status.
module counter_extend_sampler
  import counter_ext_pkg::*;
#(
  parameter int CW    = CW_DEF,
  parameter int EW    = EW_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CW-1:0]              count,
  input  logic                       overflow,
  input  logic                       sample_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EW+CW-1:0]           out_data,
  output logic [EW-1:0]              epoch,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [7:0]                 drop_cnt,
  output logic                       proto_err
);

  logic [EW-1:0]    epoch_q, epoch_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             proto_err_q, proto_err_d;
  wrap_e            wrap;
  logic             fifo_full, fifo_empty;
  logic             pop, push, drop;
  logic [EW+CW-1:0] snap;

  assign wrap = wrap_decode(overflow, count == '0, &count);

  always_comb begin
    epoch_d     = epoch_q;
    proto_err_d = proto_err_q;
    case (wrap)
      WRAP_UP:   epoch_d = epoch_q + EW'(1);
      WRAP_DOWN: epoch_d = epoch_q - EW'(1);
      WRAP_BAD:  proto_err_d = 1'b1;
      default:   epoch_d = epoch_q;
    endcase
  end

  // Snapshot uses the post-wrap epoch so a coincident wrap is reflected.
  assign snap = {epoch_d, count};

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = sample_req & (~fifo_full | pop);
  assign drop = sample_req & ~push;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q     <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      epoch_q     <= epoch_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  snap_fifo #(
    .W     (EW + CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (snap),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid = ~fifo_empty;
  assign epoch     = epoch_q;
  assign drop_cnt  = drop_cnt_q;
  assign proto_err = proto_err_q;

endmodule
